// File: rtl/add_layer_if.sv
// add_layer_if: handshake and buffer-control bundle between the add-layer controller and its environment
interface add_layer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic valid_in_1;
  logic valid_in_2;
  logic out_ready;
  logic wr_en_1;
  logic [ADDR_WIDTH-1:0] wr_addr_1;
  logic wr_en_2;
  logic [ADDR_WIDTH-1:0] wr_addr_2;
  logic rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic valid_out;
  logic busy;
  logic frame_done;
  logic overflow_err;
  modport master (
    output valid_in_1, valid_in_2, out_ready,
    input wr_en_1, wr_addr_1, wr_en_2, wr_addr_2, rd_en, rd_addr, valid_out, busy, frame_done, overflow_err
  );
  modport slave (
    input valid_in_1, valid_in_2, out_ready,
    output wr_en_1, wr_addr_1, wr_en_2, wr_addr_2, rd_en, rd_addr, valid_out, busy, frame_done, overflow_err
  );
endinterface

// File: rtl/add_layer_ctrl.sv
// add_layer_ctrl: fill/drain/flush sequencer for the residual elementwise-add stage
module add_layer_ctrl #(
  parameter int D = 220,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2
) (
  input logic clk,
  input logic reset,
  add_layer_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] N = (ADDR_WIDTH + 1)'(D * D);
  typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [RD_LATENCY-1:0] vsr_q, vsr_d;
  logic ovf_q, ovf_d, done_q, done_d;
  logic wr1, wr2, rd, last, drop;
  assign wr1 = bus.valid_in_1 && state_q == FILL && cnt1_q < N;
  assign wr2 = bus.valid_in_2 && state_q == FILL && cnt2_q < N;
  assign rd = state_q == DRAIN && bus.out_ready;
  assign last = rd && {1'b0, rd_addr_q} == N - 1'b1;
  assign drop = (bus.valid_in_1 && !wr1) || (bus.valid_in_2 && !wr2);
  assign bus.wr_en_1 = wr1;
  assign bus.wr_addr_1 = cnt1_q[ADDR_WIDTH-1:0];
  assign bus.wr_en_2 = wr2;
  assign bus.wr_addr_2 = cnt2_q[ADDR_WIDTH-1:0];
  assign bus.rd_en = rd;
  assign bus.rd_addr = rd_addr_q;
  assign bus.valid_out = vsr_q[RD_LATENCY-1];
  assign bus.busy = state_q != FILL;
  assign bus.frame_done = done_q;
  assign bus.overflow_err = ovf_q;
  always_comb begin
    vsr_d = RD_LATENCY'({vsr_q, rd});
    done_d = state_q == FLUSH && vsr_d == '0;
    ovf_d = ovf_q | drop;
    cnt1_d = done_d ? '0 : cnt1_q + {{ADDR_WIDTH{1'b0}}, wr1};
    cnt2_d = done_d ? '0 : cnt2_q + {{ADDR_WIDTH{1'b0}}, wr2};
    rd_addr_d = done_d ? '0 : (rd && !last) ? rd_addr_q + 1'b1 : rd_addr_q;
    state_d = (state_q == FILL && cnt1_d == N && cnt2_d == N) ? DRAIN :
              last ? FLUSH :
              done_d ? FILL : state_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FILL;
      cnt1_q <= '0;
      cnt2_q <= '0;
      rd_addr_q <= '0;
      vsr_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      rd_addr_q <= rd_addr_d;
      vsr_q <= vsr_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
endmodule

// File: doc/add_layer_ctrl.md
Name: add_layer_ctrl

Overview:
- Sequencing controller for the residual elementwise-add stage: two D*D feature-map buffers feed a registered adder.
- Generates independent write addresses for both input streams and detects when both frames are complete.
- Then issues a backpressure-aware read sweep to both buffers, aligns valid_out to the read+add pipeline latency, and rearms for the next frame.
- Contains no datapath storage; drives external buffer and adder enables only.

Parameters:
D, 220, feature-map side length; frame holds N = D*D pixels.
ADDR_WIDTH, 16, buffer address width; must satisfy 2^ADDR_WIDTH >= D*D.
RD_LATENCY, 2, cycles from rd_en to the adder result being registered at the stage output (1..8).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
valid_in_1  input  1  stream 1 pixel present this cycle
valid_in_2  input  1  stream 2 pixel present this cycle
out_ready  input  1  downstream may accept a new read issue this cycle
wr_en_1  output  1  write strobe, buffer 1
wr_addr_1  output  ADDR_WIDTH  write address, buffer 1
wr_en_2  output  1  write strobe, buffer 2
wr_addr_2  output  ADDR_WIDTH  write address, buffer 2
rd_en  output  1  read strobe, both buffers (shared address)
rd_addr  output  ADDR_WIDTH  read address, both buffers
valid_out  output  1  adder output valid, aligned to the pipeline
busy  output  1  high in DRAIN and FLUSH
frame_done  output  1  one-cycle pulse when the last result has left the pipeline
overflow_err  output  1  sticky: an input beat was dropped

Behaviour:
- Reset (reset==0 at a clk edge): state=FILL; both write counters, rd_addr and the valid shift register are cleared; all outputs are 0, including overflow_err. Reset asserted mid-frame aborts the frame, and no frame_done is generated.
- Write path is combinational off registered counters: wr_en_k = valid_in_k && (state==FILL) && (cnt_k < N); wr_addr_k = cnt_k. cnt_k increments on each wr_en_k.
- The two streams are fully independent: arbitrary interleaving, either may finish first, and simultaneous beats are both accepted.
- A dropped beat is valid_in_k while cnt_k==N, or while state is DRAIN or FLUSH. Drops are not written and set overflow_err=1 until reset.
- FILL -> DRAIN on the cycle after both cnt_1==N and cnt_2==N. This includes the case where both final beats arrive in the same cycle.
- DRAIN:
  - rd_en = out_ready (combinational); rd_addr increments on rd_en, starting at 0.
  - out_ready low stalls issue only. Reads already issued still complete, so downstream must absorb up to RD_LATENCY in-flight results.
  - An issue with rd_addr==N-1 moves the state to FLUSH; rd_addr is not incremented past N-1.
- valid_out = rd_en delayed by exactly RD_LATENCY cycles through a shift register that runs every cycle and is not gated by out_ready. A stream of N reads therefore yields exactly N valid_out cycles.
- FLUSH:
  - Wait until the shift register is empty, i.e. the cycle where the last valid_out is high.
  - Pulse frame_done in the cycle after that last valid_out.
  - Then return to FILL with cnt_1=cnt_2=rd_addr=0 and busy=0.
  - Inputs are accepted from the first FILL cycle onward.
- Counters never wrap. All compares are against the constant N at ADDR_WIDTH+1 bits, so a counter can hold the value N.

Test Plan:
- D=4, RD_LATENCY=2; 16 beats on each stream simultaneously, out_ready=1 -> wr_addr 0..15 on both ports; DRAIN starts the next cycle; rd_addr 0..15 on consecutive cycles; valid_out high for 16 cycles starting 2 cycles after the first rd_en; frame_done 1 cycle after the last valid_out; overflow_err=0.
- Stream 1 complete (16 beats), then stream 2 sends 16 beats with gaps -> no rd_en until 1 cycle after stream 2's 16th beat; then identical drain.
- In DRAIN, toggle out_ready 1,0,0,1,... -> rd_addr advances only on out_ready=1; valid_out reproduces the rd_en pattern exactly 2 cycles later; total valid_out count = 16.
- Stream 1 sends 17 beats before stream 2 finishes -> 17th beat has wr_en_1=0, overflow_err=1 and remains 1 through frame_done; drain is unaffected. Then a beat arrives during DRAIN -> no write.
- Reset pulse (reset=0 for 1 cycle) at rd_addr=7 -> all outputs 0 next cycle; state FILL; no frame_done; a fresh 16+16 frame then completes normally.
- Two back-to-back frames -> second frame writes start at address 0 on the first FILL cycle after frame_done; second frame_done observed; no spurious valid_out between frames.
